// File: rtl/demux_sched_pkg.sv
// Shared constants for the credit-based 1-to-4 demux scheduler.
package demux_sched_pkg;

  localparam int NCH = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
    return NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_sched_rr_pick4.sv
// Round-robin pick: first available channel at or after ptr, wrapping mod 4.
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0] avail,
  input  logic [1:0]     ptr,
  output logic [1:0]     target,
  output logic           found
);

  logic [1:0] idx;

  // Scan farthest-first so the closest available channel to ptr wins.
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (avail[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_sched.sv
// Credit-based round-robin scheduler driving a 1-to-4 demux select and strobes.
module demux_sched
  import demux_sched_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CREDITS = 4,
  parameter int CW      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic [1:0]     sel,
  output logic [DW-1:0]  out_data,
  output logic [NCH-1:0] out_valid,
  input  logic [NCH-1:0] credit_ret,
  output logic [15:0]    xfer_cnt,
  output logic           cred_err,
  output logic [1:0]     state
);

  logic [NCH-1:0][CW-1:0] credit;
  logic [NCH-1:0][CW-1:0] credit_nxt;
  logic [NCH-1:0]         avail;
  logic [NCH-1:0]         dec;
  logic [NCH-1:0]         ret_ovf;
  logic [NCH-1:0]         nxt_nz;
  logic [1:0]             ptr;
  logic [1:0]             target;
  logic                   found;
  logic                   accept;
  logic [1:0]             state_q;
  logic [1:0]             state_nxt;

  logic [DW-1:0]          data_p1;
  logic [1:0]             sel_p1;
  logic [NCH-1:0]         vld_p1;
  logic [15:0]            xfer_q;
  logic                   err_q;

  // Saturating credit update: a return into a full counter is dropped.
  function automatic logic [CW-1:0] credit_step(input logic [CW-1:0] c,
                                                input logic r,
                                                input logic d);
    if (r && !d)
      return (c == CW'(CREDITS)) ? c : c + CW'(1);
    if (d && !r)
      return c - CW'(1);
    return c;
  endfunction

  rr_pick4 u_pick (
    .avail  (avail),
    .ptr    (ptr),
    .target (target),
    .found  (found)
  );

  // en gates the handshake so a cycle with en low can never accept.
  assign in_ready = (state_q == RUN) && en && found;
  assign accept   = in_valid && in_ready;
  assign dec      = accept ? onehot4(target) : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_cred
    logic [CW-1:0] cnt;

    assign credit[i]     = cnt;
    assign avail[i]      = (cnt != '0);
    assign credit_nxt[i] = credit_step(cnt, credit_ret[i], dec[i]);
    assign nxt_nz[i]     = (credit_nxt[i] != '0);
    assign ret_ovf[i]    = credit_ret[i] && !dec[i] && (cnt == CW'(CREDITS));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= CW'(CREDITS);
      else        cnt <= credit_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (!en)          state_nxt = IDLE;
        else if (~|nxt_nz) state_nxt = STALL;
      end
      STALL: begin
        if (!en)         state_nxt = IDLE;
        else if (|nxt_nz) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered item, select and one-cycle strobe toward the demux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr     <= 2'd0;
      vld_p1  <= '0;
      sel_p1  <= 2'd0;
      data_p1 <= '0;
      xfer_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      vld_p1  <= dec;
      err_q   <= err_q | (|ret_ovf);
      if (accept) begin
        data_p1 <= in_data;
        sel_p1  <= target;
        ptr     <= target + 2'd1;
        xfer_q  <= xfer_q + 16'd1;
      end
    end
  end

  assign out_data  = data_p1;
  assign sel       = sel_p1;
  assign out_valid = vld_p1;
  assign xfer_cnt  = xfer_q;
  assign cred_err  = err_q;
  assign state     = state_q;

endmodule
